// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//   Bundles the writeback-arbiter bus: pipeline WB request, M-unit result
//   handshake, register-file write port and the hazard-side pending status.
//   slave  : the arbiter (takes requests, drives RF/status)
//   master : the surroundings (pipeline, M-unit, register file, hazard unit)
interface regfile_wb_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic              WB_VALID;
  logic [ADDR_W-1:0] WB_ADDR;
  logic [DATA_W-1:0] WB_DATA;
  logic              WB_STALL;

  logic              M_VALID;
  logic              M_READY;
  logic [ADDR_W-1:0] M_ADDR;
  logic [DATA_W-1:0] M_DATA;

  logic              RF_WRITEENABLE;
  logic [ADDR_W-1:0] RF_WRITEADDRESS;
  logic [DATA_W-1:0] RF_WRITEDATA;

  logic [31:0]       PEND_MASK;
  logic [CNT_W-1:0]  PENDING_COUNT;

  modport slave (
    input  WB_VALID, WB_ADDR, WB_DATA, M_VALID, M_ADDR, M_DATA,
    output WB_STALL, M_READY, RF_WRITEENABLE, RF_WRITEADDRESS, RF_WRITEDATA,
           PEND_MASK, PENDING_COUNT
  );

  modport master (
    output WB_VALID, WB_ADDR, WB_DATA, M_VALID, M_ADDR, M_DATA,
    input  WB_STALL, M_READY, RF_WRITEENABLE, RF_WRITEADDRESS, RF_WRITEDATA,
           PEND_MASK, PENDING_COUNT
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between the pipeline WB stage
//   (priority) and queued M-unit results. M results wait in a small FIFO and
//   drain into free slots; after STARVE_LIMIT consecutive lost slots the FIFO
//   head is forced through and the pipeline is stalled for that cycle.
// Ports
//   CLK   : clock, rising edge
//   RESET : synchronous, active-low reset
//   bus   : slave side of regfile_wb_arbiter_if (WB request/stall, M handshake,
//           RF write port, PEND_MASK, PENDING_COUNT)
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_WB   = 2'd1,
    SEL_FIFO = 2'd2
  } sel_e;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  logic              fifo_empty;
  logic              m_ready;
  logic              wb_req;
  logic              force_pop;
  logic              push;
  logic              pop;
  sel_e              sel;
  logic [31:0]       pend_mask;

  assign fifo_empty = (count_q == '0);
  // Readiness depends on occupancy only: a full FIFO does not accept even if
  // it pops in the same cycle.
  assign m_ready    = RESET && (count_q < CNT_W'(FIFO_DEPTH));
  // A write to x0 is not a real request and leaves the slot for the FIFO.
  assign wb_req     = bus.WB_VALID && (bus.WB_ADDR != '0);
  assign force_pop  = !fifo_empty && (starve_q == STV_W'(STARVE_LIMIT));
  // Results for x0 are handshaken but never stored.
  assign push       = bus.M_VALID && m_ready && (bus.M_ADDR != '0);
  assign pop        = (sel == SEL_FIFO);

  always_comb begin
    sel = SEL_NONE;
    if (force_pop) begin
      sel = SEL_FIFO;
    end else if (wb_req) begin
      sel = SEL_WB;
    end else if (!fifo_empty) begin
      sel = SEL_FIFO;
    end
  end

  always_comb begin
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    case (sel)
      SEL_WB: begin
        rf_we_d   = 1'b1;
        rf_addr_d = bus.WB_ADDR;
        rf_data_d = bus.WB_DATA;
      end
      SEL_FIFO: begin
        rf_we_d   = 1'b1;
        rf_addr_d = fifo_addr_q[rd_ptr_q];
        rf_data_d = fifo_data_q[rd_ptr_q];
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if ((sel == SEL_WB) && (starve_q != STV_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Storage needs no reset: validity is carried by the pointers and count.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.M_ADDR;
      fifo_data_q[wr_ptr_q] <= bus.M_DATA;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    logic [PTR_W-1:0] off;
    off       = '0;
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if (CNT_W'(off) < count_q) begin
        pend_mask = pend_mask | (32'(1) << fifo_addr_q[i]);
      end
    end
  end

  assign bus.M_READY         = m_ready;
  assign bus.WB_STALL        = RESET && force_pop;
  assign bus.RF_WRITEENABLE  = rf_we_q;
  assign bus.RF_WRITEADDRESS = rf_addr_q;
  assign bus.RF_WRITEDATA    = rf_data_q;
  assign bus.PEND_MASK       = pend_mask;
  assign bus.PENDING_COUNT   = count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed vector table, hand-written starvation and mid-reset sequences,
//   then randomized traffic checked against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic CLK = 1'b0;
  logic RESET;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) bus ();

  regfile_wb_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  typedef struct {
    logic        rst;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        e_ready;
    logic        e_stall;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_mask;
    logic [1:0]  e_cnt;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } entry_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic wv, input logic [4:0] wa,
                       input logic [31:0] wd, input logic mv, input logic [4:0] ma,
                       input logic [31:0] md);
    RESET        = rst;
    bus.WB_VALID = wv;
    bus.WB_ADDR  = wa;
    bus.WB_DATA  = wd;
    bus.M_VALID  = mv;
    bus.M_ADDR   = ma;
    bus.M_DATA   = md;
  endtask

  // Combinational outputs checked mid-cycle, registered ones just after the edge.
  task automatic step_chk(input string nm, input logic er, input logic es,
                          input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
                          input logic [31:0] em, input logic [1:0] ec);
    @(negedge CLK);
    chk({nm, ".m_ready"}, 32'(bus.M_READY), 32'(er));
    chk({nm, ".wb_stall"}, 32'(bus.WB_STALL), 32'(es));
    @(posedge CLK);
    #1;
    chk({nm, ".we"}, 32'(bus.RF_WRITEENABLE), 32'(ewe));
    chk({nm, ".waddr"}, 32'(bus.RF_WRITEADDRESS), 32'(ea));
    chk({nm, ".wdata"}, bus.RF_WRITEDATA, ed);
    chk({nm, ".pend_mask"}, bus.PEND_MASK, em);
    chk({nm, ".count"}, 32'(bus.PENDING_COUNT), 32'(ec));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    entry_t      mq[$];
    int          mstarve;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        e_ready, e_stall, wbreq, frc, popped, was_empty, last_stall;
    logic [31:0] e_mask;
    logic [4:0]  a_sel, a_v;
    logic [31:0] d_v;

    // rst wv wa wd mv ma md | ready stall we addr data mask cnt
    vecs[0]  = '{1'b0, 1'b1, 5'd5, 32'h1, 1'b1, 5'd3, 32'h3,
                 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'd0};
    vecs[1]  = vecs[0];
    vecs[2]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'd0};
    vecs[3]  = '{1'b1, 1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b1, 5'd5, 32'hA5A5A5A5, 32'h0, 2'd0};
    vecs[4]  = '{1'b1, 1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b0, 5'd5, 32'hA5A5A5A5, 32'h0, 2'd0};
    vecs[5]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12345678,
                 1'b1, 1'b0, 1'b0, 5'd5, 32'hA5A5A5A5, 32'h80, 2'd1};
    vecs[6]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b1, 5'd7, 32'h12345678, 32'h0, 2'd0};
    vecs[7]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF,
                 1'b1, 1'b0, 1'b0, 5'd7, 32'h12345678, 32'h0, 2'd0};
    vecs[8]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b0, 5'd7, 32'h12345678, 32'h0, 2'd0};
    vecs[9]  = '{1'b1, 1'b0, 5'd9, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b0, 5'd7, 32'h12345678, 32'h0, 2'd0};
    vecs[10] = '{1'b1, 1'b1, 5'd2, 32'h22222222, 1'b1, 5'd10, 32'hAAAAAAAA,
                 1'b1, 1'b0, 1'b1, 5'd2, 32'h22222222, 32'h400, 2'd1};
    vecs[11] = '{1'b1, 1'b1, 5'd0, 32'h33333333, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b1, 5'd10, 32'hAAAAAAAA, 32'h0, 2'd0};

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].wv, vecs[i].wa, vecs[i].wd,
            vecs[i].mv, vecs[i].ma, vecs[i].md);
      step_chk($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_stall, vecs[i].e_we,
               vecs[i].e_addr, vecs[i].e_data, vecs[i].e_mask, vecs[i].e_cnt);
    end

    // Contention: pipeline holds x1 while x8 and x9 queue up behind it.
    for (int k = 0; k < 12; k++) begin
      if (k == 0)      drive(1'b1, 1'b1, 5'd1, 32'hC0DE0001, 1'b1, 5'd8, 32'h88888888);
      else if (k == 1) drive(1'b1, 1'b1, 5'd1, 32'hC0DE0001, 1'b1, 5'd9, 32'h99999999);
      else             drive(1'b1, 1'b1, 5'd1, 32'hC0DE0001, 1'b0, 5'd0, 32'h0);
      step_chk($sformatf("starve%0d", k),
               (k <= 1) || (k >= 6),
               (k == 5) || (k == 10),
               1'b1,
               (k == 5) ? 5'd8 : (k == 10) ? 5'd9 : 5'd1,
               (k == 5) ? 32'h88888888 : (k == 10) ? 32'h99999999 : 32'hC0DE0001,
               (k == 0) ? 32'h100 : (k <= 4) ? 32'h300 : (k <= 9) ? 32'h200 : 32'h0,
               (k == 0) ? 2'd1 : (k <= 4) ? 2'd2 : (k <= 9) ? 2'd1 : 2'd0);
    end

    // Reset with a full queue: x3/x4 must never reach the register file.
    drive(1'b1, 1'b1, 5'd1, 32'hC0DE0002, 1'b1, 5'd3, 32'h33);
    step_chk("mrst_fill0", 1'b1, 1'b0, 1'b1, 5'd1, 32'hC0DE0002, 32'h8, 2'd1);
    drive(1'b1, 1'b1, 5'd1, 32'hC0DE0002, 1'b1, 5'd4, 32'h44);
    step_chk("mrst_fill1", 1'b1, 1'b0, 1'b1, 5'd1, 32'hC0DE0002, 32'h18, 2'd2);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step_chk("mrst_rst", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'd0);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step_chk($sformatf("mrst_after%0d", k), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'd0);
    end

    // Randomized traffic against a queue model; state is known-clear here.
    mq.delete();
    mstarve    = 0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_data     = '0;
    last_stall = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      RESET = ($urandom_range(0, 60) != 0);
      if (!(last_stall && RESET)) begin
        bus.WB_VALID = ($urandom_range(0, 2) != 0);
        a_v          = 5'($urandom_range(0, 31));
        bus.WB_ADDR  = ($urandom_range(0, 7) == 0) ? 5'd0 : a_v;
        bus.WB_DATA  = $urandom;
      end
      bus.M_VALID = ($urandom_range(0, 1) != 0);
      a_v         = 5'($urandom_range(0, 31));
      bus.M_ADDR  = ($urandom_range(0, 7) == 0) ? 5'd0 : a_v;
      bus.M_DATA  = $urandom;

      wbreq   = bus.WB_VALID && (bus.WB_ADDR != 0);
      frc     = (mq.size() > 0) && (mstarve == LIMIT);
      e_ready = RESET && (mq.size() < DEPTH);
      e_stall = RESET && frc;

      @(negedge CLK);
      chk($sformatf("rnd%0d.m_ready", cyc), 32'(bus.M_READY), 32'(e_ready));
      chk($sformatf("rnd%0d.wb_stall", cyc), 32'(bus.WB_STALL), 32'(e_stall));
      last_stall = bus.WB_STALL;

      @(posedge CLK);
      if (!RESET) begin
        mq.delete();
        mstarve = 0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_data  = '0;
      end else begin
        was_empty = (mq.size() == 0);
        popped    = 1'b0;
        if (frc || (!wbreq && !was_empty)) begin
          m_we   = 1'b1;
          m_addr = mq[0].a;
          m_data = mq[0].d;
          void'(mq.pop_front());
          popped = 1'b1;
        end else if (wbreq) begin
          m_we   = 1'b1;
          m_addr = bus.WB_ADDR;
          m_data = bus.WB_DATA;
        end else begin
          m_we = 1'b0;
        end
        if (was_empty || popped) mstarve = 0;
        else if (mstarve < LIMIT) mstarve++;
        if (bus.M_VALID && e_ready && (bus.M_ADDR != 0)) begin
          mq.push_back('{a: bus.M_ADDR, d: bus.M_DATA});
        end
      end
      #1;
      e_mask = '0;
      foreach (mq[j]) begin
        a_sel  = mq[j].a;
        e_mask = e_mask | (32'(1) << a_sel);
      end
      chk($sformatf("rnd%0d.we", cyc), 32'(bus.RF_WRITEENABLE), 32'(m_we));
      chk($sformatf("rnd%0d.waddr", cyc), 32'(bus.RF_WRITEADDRESS), 32'(m_addr));
      chk($sformatf("rnd%0d.wdata", cyc), bus.RF_WRITEDATA, m_data);
      chk($sformatf("rnd%0d.pend_mask", cyc), bus.PEND_MASK, e_mask);
      chk($sformatf("rnd%0d.count", cyc), 32'(bus.PENDING_COUNT), 32'(mq.size()));
      d_v = 32'(mstarve);
      if (d_v > LIMIT) begin
        errors++;
        $display("FAIL model_starve: got %0d expected <= %0d", d_v, LIMIT);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
